// File: rtl/arinc_tx_scheduler.sv
// Round-robin arbiter that shares one ARINC-429 TX FIFO write port among NUM_REQ word sources.
// After each write it holds off for HOLDOFF cycles, so the next grant sees a free_words value that already includes that write.
module arinc_tx_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int MIN_FREE = 1,
   parameter int HOLDOFF  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*32-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [9:0]             free_words,
   output logic [31:0]            bufer_data,
   output logic                   bufer_wr,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic                   fifo_stall,
   output logic [15:0]            words_sent
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(HOLDOFF + 1);
   localparam logic [9:0]       MIN_FREE_W = 10'(MIN_FREE);
   localparam logic [CNT_W-1:0] HOLDOFF_W  = CNT_W'(HOLDOFF);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      SETTLE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]       rr_ptr;
   logic [2:0]       winner;
   logic             found;
   logic [IDX_W-1:0] idx;
   logic [31:0]      win_data;
   logic [CNT_W-1:0] settle_cnt;
   logic             space_ok;
   logic             grant;

   // Search starts one past the last winner, so every requester gets a turn within NUM_REQ grants
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = 3'(idx);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (winner == 3'(j)) begin
            win_data = req_data[32*j +: 32];
         end
      end
   end

   assign space_ok = (free_words >= MIN_FREE_W);
   assign grant    = (state == IDLE) && enable && found && space_ok;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = WRITE;
         WRITE:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == CNT_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The write strobe and the acknowledge come from the same grant, so they are always high in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bufer_wr   <= 1'b0;
         req_ready  <= '0;
         bufer_data <= '0;
         grant_id   <= '0;
         rr_ptr     <= 3'(NUM_REQ - 1);
         settle_cnt <= '0;
         fifo_stall <= 1'b0;
         words_sent <= '0;
      end else begin
         bufer_wr   <= grant;
         req_ready  <= grant ? (NUM_REQ'(1) << winner) : '0;
         fifo_stall <= (state == IDLE) && enable && (|req_valid) && !space_ok;
         if (grant) begin
            bufer_data <= win_data;
            grant_id   <= winner;
            rr_ptr     <= winner;
         end
         if (state == WRITE) begin
            words_sent <= words_sent + 16'd1;
            settle_cnt <= HOLDOFF_W;
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_arinc_tx_scheduler.sv
// Directed bench for arinc_tx_scheduler covering grant latency, round-robin order, FIFO-space stall,
// the enable gate, reset during a write and the words_sent wrap.
module tb_arinc_tx_scheduler;

   logic          clk;
   logic          reset;
   logic          enable;
   logic [3:0]    req_valid;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic [9:0]    free_words;
   logic [31:0]   bufer_data;
   logic          bufer_wr;
   logic [2:0]    grant_id;
   logic          busy;
   logic          fifo_stall;
   logic [15:0]   words_sent;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   arinc_tx_scheduler #(.NUM_REQ(4), .MIN_FREE(1), .HOLDOFF(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .free_words (free_words),
      .bufer_data (bufer_data),
      .bufer_wr   (bufer_wr),
      .grant_id   (grant_id),
      .busy       (busy),
      .fifo_stall (fifo_stall),
      .words_sent (words_sent)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic wait_wr(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (bufer_wr === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit seen;
      int last_cyc;
      int wrs;
      int lows;
      int exp_id;

      reset      = 1'b1;
      enable     = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      free_words = 10'd512;

      // Reset values
      #12;
      check_output("rst_bufer_wr",   32'(bufer_wr),   32'd0);
      check_output("rst_req_ready",  32'(req_ready),  32'd0);
      check_output("rst_bufer_data", bufer_data,      32'd0);
      check_output("rst_grant_id",   32'(grant_id),   32'd0);
      check_output("rst_busy",       32'(busy),       32'd0);
      check_output("rst_fifo_stall", 32'(fifo_stall), 32'd0);
      check_output("rst_words_sent", 32'(words_sent), 32'd0);

      // Single requester: write strobe one cycle after the request
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      req_data[95:64] = 32'hA5A5_0123;
      req_valid = 4'b0100;
      tick();
      check_output("t1_bufer_wr",   32'(bufer_wr),  32'd1);
      check_output("t1_bufer_data", bufer_data,     32'hA5A5_0123);
      check_output("t1_req_ready",  32'(req_ready), 32'h4);
      check_output("t1_grant_id",   32'(grant_id),  32'd2);
      check_output("t1_busy",       32'(busy),      32'd1);
      req_valid = 4'b0000;
      tick();
      check_output("t1_wr_drop",    32'(bufer_wr),   32'd0);
      check_output("t1_ready_drop", 32'(req_ready),  32'd0);
      check_output("t1_words_sent", 32'(words_sent), 32'd1);
      repeat (3) tick();
      check_output("t1_idle_busy",  32'(busy),       32'd0);

      // All four valid: round robin 0,1,2,3,0 with 5-cycle spacing
      apply_reset();
      req_data = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      req_valid = 4'hF;
      enable = 1'b1;
      free_words = 10'd512;
      last_cyc = 0;
      for (int g = 0; g < 5; g++) begin
         exp_id = g % 4;
         wait_wr(8, seen);
         check_output("rr_timeout",  32'(seen),      32'd1);
         check_output("rr_grant_id", 32'(grant_id),  32'(exp_id));
         check_output("rr_req_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
         check_output("rr_bufer_data", bufer_data, 32'hD0D0_0000 + 32'h0101_0001 * 32'(exp_id));
         if (g > 0) begin
            check_output("rr_spacing", 32'(cycle - last_cyc), 32'd5);
         end
         last_cyc = cycle;
         tick();
         check_output("rr_ready_width", 32'(req_ready), 32'd0);
      end

      // No free space: stall and no writes, then release with free_words=5
      req_valid = 4'b0000;
      apply_reset();
      free_words = 10'd0;
      req_data[63:32] = 32'h0B0B_1111;
      req_valid = 4'b0010;
      enable = 1'b1;
      tick();
      check_output("st_first_stall", 32'(fifo_stall), 32'd1);
      wrs = 0;
      lows = 0;
      repeat (20) begin
         tick();
         if (bufer_wr !== 1'b0) wrs++;
         if (fifo_stall !== 1'b1) lows++;
      end
      check_output("st_no_writes", 32'(wrs),  32'd0);
      check_output("st_stall_held", 32'(lows), 32'd0);
      free_words = 10'd5;
      tick();
      check_output("st_release_wr",    32'(bufer_wr),   32'd1);
      check_output("st_release_stall", 32'(fifo_stall), 32'd0);
      check_output("st_release_id",    32'(grant_id),   32'd1);
      check_output("st_release_data",  bufer_data,      32'h0B0B_1111);
      req_valid = 4'b0000;
      repeat (4) tick();
      check_output("st_words_sent", 32'(words_sent), 32'd1);

      // Enable drops during the write of requester 3; free_words at exactly MIN_FREE
      free_words = 10'd1;
      req_data[127:96] = 32'h3333_CAFE;
      req_valid = 4'b1000;
      tick();
      check_output("en_wr3",      32'(bufer_wr), 32'd1);
      check_output("en_grant3",   32'(grant_id), 32'd3);
      check_output("en_data3",    bufer_data,    32'h3333_CAFE);
      enable = 1'b0;
      req_valid = 4'hF;
      tick();
      check_output("en_wr_done",    32'(bufer_wr),   32'd0);
      check_output("en_words_sent", 32'(words_sent), 32'd2);
      wrs = 0;
      repeat (15) begin
         tick();
         if (bufer_wr !== 1'b0) wrs++;
      end
      check_output("en_no_writes", 32'(wrs),        32'd0);
      check_output("en_idle_busy", 32'(busy),       32'd0);
      check_output("en_no_stall",  32'(fifo_stall), 32'd0);
      req_data[31:0] = 32'h0000_00AA;
      enable = 1'b1;
      tick();
      check_output("en_rewr",      32'(bufer_wr),  32'd1);
      check_output("en_regrant0",  32'(grant_id),  32'd0);
      check_output("en_reready",   32'(req_ready), 32'd1);
      check_output("en_redata",    bufer_data,     32'h0000_00AA);

      // Asynchronous reset in the middle of that write
      reset = 1'b1;
      #1;
      check_output("ar_bufer_wr",   32'(bufer_wr),   32'd0);
      check_output("ar_req_ready",  32'(req_ready),  32'd0);
      check_output("ar_busy",       32'(busy),       32'd0);
      check_output("ar_words_sent", 32'(words_sent), 32'd0);
      #2;
      reset = 1'b0;
      tick();
      check_output("ar_first_wr",    32'(bufer_wr), 32'd1);
      check_output("ar_first_grant", 32'(grant_id), 32'd0);

      // words_sent wrap from 0xFFFF; free_words above 512 still grants
      req_valid = 4'b0000;
      repeat (4) tick();
      check_output("wr_pre_count", 32'(words_sent), 32'd1);
      force dut.words_sent = 16'hFFFF;
      #1;
      release dut.words_sent;
      check_output("wr_preload", 32'(words_sent), 32'h0000_FFFF);
      free_words = 10'h3FF;
      req_valid = 4'b0100;
      tick();
      check_output("wr_big_free", 32'(bufer_wr), 32'd1);
      req_valid = 4'b0000;
      tick();
      check_output("wr_wrapped", 32'(words_sent), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
